// File: rtl/dmem_pkg.sv
// Shared encodings for the data-SRAM controller: request sizes, FSM states
// and the SRAM control vectors {we_n, ce_n, oe_n, lb_n, ub_n}.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_WR0,
      ST_WR1,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_DONE
   } state_t;

   localparam logic [4:0] CTL_IDLE  = 5'b11111;
   localparam logic [4:0] CTL_READ  = 5'b10000;
   localparam logic [4:0] CTL_WRITE = 5'b00100;

endpackage

// File: rtl/dmem_lane_align.sv
// Load-side byte/half extraction with sign/zero extension, and store-side
// byte-lane merge for read-modify-write. Halfwords are big-endian by byte.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic        byte_sel,
   input  logic [31:0] rd_word,
   input  logic [7:0]  wbyte,
   output logic [31:0] load_data,
   output logic [15:0] merged_half
);

   logic [7:0] lane_byte;

   assign lane_byte = byte_sel ? rd_word[7:0] : rd_word[15:8];

   always_comb begin
      load_data = rd_word;
      case (size)
         SZ_BYTE: load_data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
         SZ_HALF: load_data = {{16{~is_unsigned & rd_word[15]}}, rd_word[15:0]};
         default: load_data = rd_word;
      endcase
   end

   // Byte address bit0=0 is the upper lane of the halfword.
   assign merged_half = byte_sel ? {rd_word[15:8], wbyte} : {wbyte, rd_word[7:0]};

endmodule

// File: rtl/dmem_ctrl.sv
// CPU load/store to 16-bit external SRAM bridge. Word accesses take two
// halfword cycles (high half first); byte stores are read-modify-write.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request, SRAM deselected
// RD0       | read cycle at haddr (whole load, or high half of word)
// RD1       | read cycle at haddr+1 (low half of word load)
// WR0       | write cycle at haddr (half store, or high half of word)
// WR1       | write cycle at haddr+1 (low half of word store)
// RMW_RD    | read halfword to be partially overwritten by a byte store
// RMW_WR    | write back halfword with the selected byte lane replaced
// DONE      | one-cycle response pulse
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int AW   = 20,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic [AW-1:0]   sram_addr,
   output logic            sram_we_n,
   output logic            sram_ce_n,
   output logic            sram_oe_n,
   output logic            sram_lb_n,
   output logic            sram_ub_n,
   inout  wire  [15:0]     sram_data
);

   state_t      state;
   logic [4:0]  sram_ctl;
   logic        bus_oe;
   logic [15:0] bus_out;
   logic [15:0] rd_hi;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        r_bsel;
   logic [15:0] r_wlo;
   logic        req_err;
   logic [31:0] load_data;
   logic [15:0] merged_half;

   assign {sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n} = sram_ctl;
   assign sram_data = bus_oe ? bus_out : 16'hzzzz;

   always_comb begin
      req_err = (req_size == 2'd3)
             || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
             || (req_size == SZ_HALF && req_addr[0])
             || (req_addr[XLEN-1:AW+1] != '0);
   end

   dmem_lane_align u_align (
      .size        (r_size),
      .is_unsigned (r_uns),
      .byte_sel    (r_bsel),
      .rd_word     ({rd_hi, sram_data}),
      .wbyte       (r_wlo[7:0]),
      .load_data   (load_data),
      .merged_half (merged_half)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         sram_addr  <= '0;
         sram_ctl   <= CTL_IDLE;
         bus_oe     <= 1'b0;
         bus_out    <= '0;
         rd_hi      <= '0;
         r_size     <= SZ_BYTE;
         r_uns      <= 1'b0;
         r_bsel     <= 1'b0;
         r_wlo      <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_size    <= req_size;
                  r_uns     <= req_unsigned;
                  r_bsel    <= req_addr[0];
                  r_wlo     <= req_wdata[15:0];
                  if (req_err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                     state      <= ST_DONE;
                  end else begin
                     sram_addr <= req_addr[AW:1];
                     if (!req_we) begin
                        sram_ctl <= CTL_READ;
                        state    <= ST_RD0;
                     end else if (req_size == SZ_BYTE) begin
                        sram_ctl <= CTL_READ;
                        state    <= ST_RMW_RD;
                     end else begin
                        sram_ctl <= CTL_WRITE;
                        bus_oe   <= 1'b1;
                        bus_out  <= (req_size == SZ_WORD) ? req_wdata[31:16] : req_wdata[15:0];
                        state    <= ST_WR0;
                     end
                  end
               end
            end
            ST_RD0, ST_RD1: begin
               if (state == ST_RD0 && r_size == SZ_WORD) begin
                  rd_hi     <= sram_data;
                  sram_addr <= sram_addr + AW'(1);
                  state     <= ST_RD1;
               end else begin
                  sram_ctl   <= CTL_IDLE;
                  resp_rdata <= load_data;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_RMW_RD: begin
               sram_ctl <= CTL_WRITE;
               bus_oe   <= 1'b1;
               bus_out  <= merged_half;
               state    <= ST_RMW_WR;
            end
            ST_WR0, ST_WR1, ST_RMW_WR: begin
               if (state == ST_WR0 && r_size == SZ_WORD) begin
                  sram_addr <= sram_addr + AW'(1);
                  bus_out   <= r_wlo;
                  state     <= ST_WR1;
               end else begin
                  sram_ctl   <= CTL_IDLE;
                  bus_oe     <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
